dcache_ctrl_fsm: RTL and testbench

Parametrised data-cache controller FSM for the pipelined core's memory stage.
- Decides hit/miss handling, performs multi-beat dirty-line write-back and line refill over a handshaked memory port, and stalls the pipeline until the access can complete.
- Generalises the single-word controller to configurable line length and variable memory latency (per-beat ack).
- Adds explicit dirty-bit and tag-update control.
- Sits between the cache data/tag arrays and the main-memory interface.

---
 rtl/dcache_pkg.sv | 13 +
 rtl/beat_counter.sv | 27 ++
 rtl/dcache_ctrl_fsm.sv | 125 ++++++++++++
 tb/tb_dcache_ctrl_fsm.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and defaults for the data-cache controller
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    FILL       = 2'd2,
    UPDATE     = 2'd3
  } state_t;

  localparam int WORDS_PER_LINE_DEF = 4;

endpackage

// File: rtl/beat_counter.sv
// rtl/beat_counter.sv - beat index counter shared by write-back and fill bursts
module beat_counter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = (count == W'(N - 1));

  // clear wins so the final acked beat returns the counter to zero
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dcache_ctrl_fsm.sv
// rtl/dcache_ctrl_fsm.sv - data-cache hit/miss controller with multi-beat write-back and refill
module dcache_ctrl_fsm
  import dcache_pkg::*;
#(
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  parameter int BEAT_W         = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic              hit,
  input  logic              dirty,
  input  logic              mem_ack,
  output logic              stall,
  output logic              cache_we,
  output logic              set_dirty,
  output logic              fill_we,
  output logic              tag_we,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [BEAT_W-1:0] beat_idx
);

  state_t              state;
  state_t              next_state;
  logic                req;
  logic                beat_ack;
  logic                last;
  logic [BEAT_W-1:0]   count;

  logic                stall_c;
  logic                cache_we_c;
  logic                set_dirty_c;
  logic                fill_we_c;
  logic                tag_we_c;
  logic                mem_rd_c;
  logic                mem_wr_c;
  logic [BEAT_W-1:0]   beat_idx_c;

  assign req      = cpu_rd | cpu_wr;
  assign beat_ack = mem_ack & ((state == WRITE_BACK) | (state == FILL));

  beat_counter #(
    .N (WORDS_PER_LINE),
    .W (BEAT_W)
  ) u_beat_counter (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (beat_ack),
    .clr   (beat_ack & last),
    .count (count),
    .last  (last)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    stall_c     = 1'b0;
    cache_we_c  = 1'b0;
    set_dirty_c = 1'b0;
    fill_we_c   = 1'b0;
    tag_we_c    = 1'b0;
    mem_rd_c    = 1'b0;
    mem_wr_c    = 1'b0;
    beat_idx_c  = '0;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            // a simultaneous load and store resolves as the store
            cache_we_c  = cpu_wr;
            set_dirty_c = cpu_wr;
          end else begin
            stall_c    = 1'b1;
            next_state = dirty ? WRITE_BACK : FILL;
          end
        end
      end
      WRITE_BACK: begin
        stall_c    = 1'b1;
        mem_wr_c   = 1'b1;
        beat_idx_c = count;
        if (mem_ack && last) begin
          next_state = FILL;
        end
      end
      FILL: begin
        stall_c    = 1'b1;
        mem_rd_c   = 1'b1;
        fill_we_c  = mem_ack;
        beat_idx_c = count;
        if (mem_ack && last) begin
          next_state = UPDATE;
        end
      end
      UPDATE: begin
        stall_c    = 1'b1;
        tag_we_c   = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Mealy terms would otherwise follow the CPU inputs while reset is held
  assign stall     = stall_c     & ~RST;
  assign cache_we  = cache_we_c  & ~RST;
  assign set_dirty = set_dirty_c & ~RST;
  assign fill_we   = fill_we_c   & ~RST;
  assign tag_we    = tag_we_c    & ~RST;
  assign mem_rd    = mem_rd_c    & ~RST;
  assign mem_wr    = mem_wr_c    & ~RST;
  assign beat_idx  = RST ? '0 : beat_idx_c;

endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
// tb/tb_dcache_ctrl_fsm.sv - vector-table and scoreboard bench for dcache_ctrl_fsm
module tb_dcache_ctrl_fsm;

  typedef struct packed {
    logic       sel;
    logic       rst;
    logic       rd;
    logic       wr;
    logic       hit;
    logic       dirty;
    logic       ack;
    logic [6:0] o;
    logic [1:0] bidx;
  } vec_t;

  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_STALL = 7'b1000000;
  localparam logic [6:0] O_STORE = 7'b0110000;
  localparam logic [6:0] O_FACK  = 7'b1001010;
  localparam logic [6:0] O_FWAIT = 7'b1000010;
  localparam logic [6:0] O_UPD   = 7'b1000100;
  localparam logic [6:0] O_WB    = 7'b1000001;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  logic rd4 = 0, wr4 = 0, hit4 = 0, dirty4 = 0, ack4 = 0;
  logic stall4, cwe4, sd4, fwe4, twe4, mrd4, mwr4;
  logic [1:0] bidx4;

  logic rd1 = 0, wr1 = 0, hit1 = 0, dirty1 = 0, ack1 = 0;
  logic stall1, cwe1, sd1, fwe1, twe1, mrd1, mwr1;
  logic [0:0] bidx1;

  int total = 0;
  int bad   = 0;
  int vec_no = 0;
  logic [8:0] exp_q[$];
  vec_t tbl[$];

  always #5 CLK = ~CLK;

  dcache_ctrl_fsm #(.WORDS_PER_LINE(4)) dut4 (
    .CLK(CLK), .RST(RST), .cpu_rd(rd4), .cpu_wr(wr4), .hit(hit4), .dirty(dirty4),
    .mem_ack(ack4), .stall(stall4), .cache_we(cwe4), .set_dirty(sd4), .fill_we(fwe4),
    .tag_we(twe4), .mem_rd(mrd4), .mem_wr(mwr4), .beat_idx(bidx4)
  );

  dcache_ctrl_fsm #(.WORDS_PER_LINE(1)) dut1 (
    .CLK(CLK), .RST(RST), .cpu_rd(rd1), .cpu_wr(wr1), .hit(hit1), .dirty(dirty1),
    .mem_ack(ack1), .stall(stall1), .cache_we(cwe1), .set_dirty(sd1), .fill_we(fwe1),
    .tag_we(twe1), .mem_rd(mrd1), .mem_wr(mwr1), .beat_idx(bidx1)
  );

  function automatic vec_t v(input logic sel, input logic rst, input logic rd,
                             input logic wr, input logic hit, input logic dirty,
                             input logic ack, input logic [6:0] o, input logic [1:0] b);
    vec_t t;
    t = '{sel: sel, rst: rst, rd: rd, wr: wr, hit: hit, dirty: dirty, ack: ack,
          o: o, bidx: b};
    return t;
  endfunction

  task automatic check(input logic sel);
    logic [8:0] exp;
    logic [8:0] act;
    exp = exp_q.pop_front();
    if (sel) act = {stall1, cwe1, sd1, fwe1, twe1, mrd1, mwr1, 1'b0, bidx1};
    else     act = {stall4, cwe4, sd4, fwe4, twe4, mrd4, mwr4, bidx4};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL vec%0d outs {stall,cwe,sdirty,fwe,twe,mrd,mwr,bidx} got=%b want=%b",
               vec_no, act, exp);
    end
    total++;
    if ((mrd4 && mwr4) || (mrd1 && mwr1)) begin
      bad++;
      $display("FAIL vec%0d mem_rd_mem_wr_exclusive got=1 want=0", vec_no);
    end
    vec_no++;
  endtask

  task automatic step(input vec_t t);
    @(negedge CLK);
    RST = t.rst;
    rd4 = t.sel ? 1'b0 : t.rd;    wr4 = t.sel ? 1'b0 : t.wr;
    hit4 = t.sel ? 1'b0 : t.hit;  dirty4 = t.sel ? 1'b0 : t.dirty;
    ack4 = t.sel ? 1'b0 : t.ack;
    rd1 = t.sel ? t.rd : 1'b0;    wr1 = t.sel ? t.wr : 1'b0;
    hit1 = t.sel ? t.hit : 1'b0;  dirty1 = t.sel ? t.dirty : 1'b0;
    ack1 = t.sel ? t.ack : 1'b0;
    exp_q.push_back({t.o, t.bidx});
    #1;
    check(t.sel);
  endtask

  initial begin
    // reset, hits, idle corner cases
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, O_NONE, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 0, 0, O_NONE, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 0, 0, O_STORE, 0));
    tbl.push_back(v(0, 0, 1, 1, 1, 1, 0, O_STORE, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, O_NONE, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, O_NONE, 0));
    // clean read miss, ack every cycle
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 1, O_STALL, 0));
    for (int b = 0; b < 4; b++) tbl.push_back(v(0, 0, 1, 0, 0, 0, 1, O_FACK, 2'(b)));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 1, O_UPD, 0));
    tbl.push_back(v(0, 0, 1, 0, 1, 0, 0, O_NONE, 0));
    // dirty store miss, ack every third cycle
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, O_STALL, 0));
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 3; w++)
        tbl.push_back(v(0, 0, 0, 1, 0, 1, w == 2, O_WB, 2'(b)));
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 3; w++)
        tbl.push_back(v(0, 0, 0, 1, 0, 1, w == 2, (w == 2) ? O_FACK : O_FWAIT, 2'(b)));
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, O_UPD, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 1, 0, O_STORE, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // reset in the middle of a fill, then a fresh miss restarts at beat 0
    step(v(0, 0, 1, 0, 0, 0, 0, O_STALL, 0));
    for (int b = 0; b < 3; b++) step(v(0, 0, 1, 0, 0, 0, 1, O_FACK, 2'(b)));
    step(v(0, 1, 1, 0, 0, 0, 1, O_NONE, 0));
    step(v(0, 0, 1, 0, 0, 0, 1, O_STALL, 0));
    step(v(0, 0, 1, 0, 0, 0, 1, O_FACK, 0));
    step(v(0, 0, 1, 0, 0, 0, 0, O_FWAIT, 1));
    step(v(0, 1, 0, 0, 0, 0, 0, O_NONE, 0));

    // single-word line: clean load miss then dirty store miss
    step(v(1, 0, 1, 0, 0, 0, 0, O_STALL, 0));
    step(v(1, 0, 1, 0, 0, 0, 0, O_FWAIT, 0));
    step(v(1, 0, 1, 0, 0, 0, 1, O_FACK, 0));
    step(v(1, 0, 1, 0, 0, 0, 0, O_UPD, 0));
    step(v(1, 0, 1, 0, 1, 0, 0, O_NONE, 0));
    step(v(1, 0, 0, 1, 0, 1, 0, O_STALL, 0));
    step(v(1, 0, 0, 1, 0, 1, 1, O_WB, 0));
    step(v(1, 0, 0, 1, 0, 1, 1, O_FACK, 0));
    step(v(1, 0, 0, 1, 0, 1, 0, O_UPD, 0));
    step(v(1, 0, 0, 1, 1, 1, 0, O_STORE, 0));

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
